// File: rtl/bascomp_pkg.sv
// Shared definitions for the basic-computer register-op datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bascomp_pkg;

  localparam int WIDTH_DEF = 16;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_CLE = 3'd1;
  localparam logic [2:0] OP_CME = 3'd2;
  localparam logic [2:0] OP_CIR = 3'd3;
  localparam logic [2:0] OP_CIL = 3'd4;
  localparam logic [2:0] OP_ADD = 3'd5;
  localparam logic [2:0] OP_SZE = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/e_op_alu.sv
// Combinational E/AC result for one register op: new E, new AC and write requests.
// Latency: zero (pure combinational).
// Backpressure: none; caller decides when the results are used.
module e_op_alu
  import bascomp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] ac,
  input  logic [WIDTH-1:0] dr,
  input  logic             old_e,
  output logic             new_e,
  output logic [WIDTH-1:0] ac_out,
  output logic             ac_ld_req,
  output logic             ff_wr_req
);

  logic [WIDTH:0] sum;

  // Decode the op into the new E bit, the new AC and which registers get written.
  always_comb begin
    sum       = {1'b0, ac} + {1'b0, dr};
    new_e     = old_e;
    ac_out    = '0;
    ac_ld_req = 1'b0;
    ff_wr_req = 1'b0;
    case (op)
      OP_CLE: begin
        new_e     = 1'b0;
        ff_wr_req = 1'b1;
      end
      OP_CME: begin
        new_e     = ~old_e;
        ff_wr_req = 1'b1;
      end
      OP_CIR: begin
        new_e     = ac[0];
        ac_out    = {old_e, ac[WIDTH-1:1]};
        ff_wr_req = 1'b1;
        ac_ld_req = 1'b1;
      end
      OP_CIL: begin
        new_e     = ac[WIDTH-1];
        ac_out    = {ac[WIDTH-2:0], old_e};
        ff_wr_req = 1'b1;
        ac_ld_req = 1'b1;
      end
      OP_ADD: begin
        new_e     = sum[WIDTH];
        ac_out    = sum[WIDTH-1:0];
        ff_wr_req = 1'b1;
        ac_ld_req = 1'b1;
      end
      default: begin
        new_e = old_e;
      end
    endcase
  end

endmodule

// File: rtl/e_flag_writer.sv
// Write-side controller for the E flip-flop: runs one E-affecting op, strobes ff/AC, verifies read-back.
// Latency: accept at edge N, strobes in cycle N+1, done in cycle N+2; next accept at edge N+3 earliest.
// Backpressure: cmd_ready only in IDLE; cmd_valid while busy is ignored, never queued.
module e_flag_writer
  import bascomp_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd_op,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] ac_in,
  input  logic [WIDTH-1:0] dr_in,
  input  logic             e_q,
  output logic             e_indata,
  output logic             e_clr,
  output logic             ff_en,
  output logic [WIDTH-1:0] ac_out,
  output logic             ac_ld,
  output logic             skip,
  output logic             done,
  output logic             wr_err
);

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic [WIDTH-1:0] dr_q, dr_d;
  logic             old_e_q, old_e_d;
  logic             wr_err_q, wr_err_d;

  logic             alu_new_e;
  logic [WIDTH-1:0] alu_ac_out;
  logic             alu_ac_ld_req;
  logic             alu_ff_wr_req;

  // Operands stay latched through CHECK, so the ALU also supplies the expected E for read-back.
  e_op_alu #(.WIDTH(WIDTH)) u_alu (
    .op        (op_q),
    .ac        (ac_q),
    .dr        (dr_q),
    .old_e     (old_e_q),
    .new_e     (alu_new_e),
    .ac_out    (alu_ac_out),
    .ac_ld_req (alu_ac_ld_req),
    .ff_wr_req (alu_ff_wr_req)
  );

  // Next-state: accept in IDLE, one cycle each in ISSUE and CHECK, sticky read-back error.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ac_d     = ac_q;
    dr_d     = dr_q;
    old_e_d  = old_e_q;
    wr_err_d = wr_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          ac_d    = ac_in;
          dr_d    = dr_in;
          old_e_d = e_q;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (CHECK_EN && alu_ff_wr_req && (e_q != alu_new_e)) begin
          wr_err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and operand registers; reset drops any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NOP;
      ac_q     <= '0;
      dr_q     <= '0;
      old_e_q  <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ac_q     <= ac_d;
      dr_q     <= dr_d;
      old_e_q  <= old_e_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Strobes exist only in ISSUE; completion and skip only in CHECK.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    ff_en     = 1'b0;
    e_clr     = 1'b0;
    e_indata  = 1'b0;
    ac_ld     = 1'b0;
    ac_out    = '0;
    done      = 1'b0;
    skip      = 1'b0;
    wr_err    = wr_err_q;
    if (state_q == ST_ISSUE) begin
      ff_en    = alu_ff_wr_req;
      e_clr    = (op_q == OP_CLE);
      e_indata = alu_ff_wr_req & alu_new_e;
      ac_ld    = alu_ac_ld_req;
      ac_out   = alu_ac_ld_req ? alu_ac_out : '0;
    end
    if (state_q == ST_CHECK) begin
      done = 1'b1;
      skip = (op_q == OP_SZE) && !old_e_q;
    end
  end

endmodule
